// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse
// symbol sequencer.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    GAP
  } state_e;

  localparam int LEN_W = 3;
  localparam int PAT_W = 6;

  localparam logic [2:0] DOT_UNITS        = 3'd1;
  localparam logic [2:0] DASH_UNITS       = 3'd3;
  localparam logic [2:0] SYM_GAP_UNITS    = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS   = 3'd3;
  localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

  localparam logic [LEN_W-1:0] MAX_SYMBOLS = 3'd6;

  function automatic logic [2:0] sym_units(
    input logic dash
  );
    return dash ? DASH_UNITS : DOT_UNITS;
  endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// Unit prescaler: counts 0..UNIT_CYCLES-1 while
// enabled and ticks on the terminal count.
module morse_unit_tick #(
  parameter int UNIT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW =
    (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM =
    CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Sequences one Morse character (dots/dashes) onto
// the key line using unit timing.
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic [LEN_W-1:0] char_len,
  input  logic [PAT_W-1:0] char_pat,
  output logic             key_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [2:0]       units_q, units_d;
  logic [2:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             done_q, done_d;

  logic             accept;
  logic             tick;
  logic             gap_end;
  logic [2:0]       idx_nxt;
  logic [LEN_W-1:0] len_clamp;

  assign busy       = (state_q != IDLE);
  assign char_ready = ena && (state_q == IDLE);
  assign accept     = char_valid && char_ready;
  assign key_out    = ena && (state_q == MARK);
  assign done       = ena && done_q;
  assign idx_nxt    = idx_q + 3'd1;
  assign len_clamp  =
    (char_len > MAX_SYMBOLS) ? MAX_SYMBOLS : char_len;

  morse_unit_tick #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ena && busy),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    units_d = units_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pat_d   = pat_q;
    gap_end = 1'b0;
    if (accept) begin
      len_d = len_clamp;
      pat_d = char_pat;
      idx_d = 3'd0;
      if (len_clamp == '0) begin
        state_d = GAP;
        units_d = WORD_EXTRA_UNITS;
      end else begin
        state_d = MARK;
        units_d = sym_units(char_pat[0]);
      end
    end else if (tick) begin
      if (units_q != 3'd1) begin
        units_d = units_q - 3'd1;
      end else begin
        unique case (state_q)
          MARK: begin
            if (idx_nxt < len_q) begin
              state_d = SPACE;
              units_d = SYM_GAP_UNITS;
            end else begin
              state_d = GAP;
              units_d = CHAR_GAP_UNITS;
            end
          end
          SPACE: begin
            idx_d   = idx_nxt;
            state_d = MARK;
            units_d = sym_units(pat_q[idx_nxt]);
          end
          GAP: begin
            state_d = IDLE;
            gap_end = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
    // done is held through a pause so it is not lost
    done_d = ena ? gap_end : done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      units_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      units_q <= units_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Self-checking bench: directed scenarios plus random
// traffic against a per-cycle timeline model.
module tb_morse_symbol_sequencer;

  localparam int U = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       char_valid;
  logic       char_ready;
  logic [2:0] char_len;
  logic [5:0] char_pat;
  logic       key_out;
  logic       busy;
  logic       done;

  int n_chk;
  int n_pass;

  // Model: remaining per-cycle key levels of the
  // current character, plus a pending done pulse.
  bit tl[$];
  bit done_pend;
  int pause_left;

  morse_symbol_sequencer #(
    .UNIT_CYCLES(U)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .char_len  (char_len),
    .char_pat  (char_pat),
    .key_out   (key_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0h want %0h",
               tag, $time, got, exp);
    end
  endtask

  function automatic void push_char(
    input logic [2:0] len,
    input logic [5:0] pat
  );
    int l;
    l = (len == 3'd7) ? 6 : int'(len);
    if (l == 0) begin
      repeat (4 * U) tl.push_back(1'b0);
    end else begin
      for (int i = 0; i < l; i++) begin
        repeat ((pat[i] ? 3 : 1) * U) tl.push_back(1'b1);
        if (i < l - 1) begin
          repeat (U) tl.push_back(1'b0);
        end
      end
      repeat (3 * U) tl.push_back(1'b0);
    end
  endfunction

  // Entered #1 after a posedge; leaves #1 after next.
  task automatic run_cycle(
    input logic       e,
    input logic       v,
    input logic [2:0] l,
    input logic [5:0] p
  );
    bit idle;
    ena        = e;
    char_valid = v;
    char_len   = l;
    char_pat   = p;
    idle = (tl.size() == 0);
    @(negedge clk);
    chk("key", 32'(key_out),
        32'(e && !idle && tl[0]));
    chk("busy", 32'(busy), 32'(!idle));
    chk("done", 32'(done), 32'(e && done_pend));
    chk("ready", 32'(char_ready), 32'(e && idle));
    @(posedge clk);
    if (e) begin
      if (!idle) begin
        void'(tl.pop_front());
        done_pend = (tl.size() == 0);
      end else begin
        done_pend = 1'b0;
      end
      if (v && idle) push_char(l, p);
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      run_cycle(1'b1, 1'b0, 3'd0, 6'd0);
    end
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    done_pend  = 1'b0;
    pause_left = 0;
    clk        = 1'b0;
    rst_n      = 1'b0;
    ena        = 1'b1;
    char_valid = 1'b0;
    char_len   = '0;
    char_pat   = '0;
    #12;
    chk("rst_key", 32'(key_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(char_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 'E'
    run_cycle(1'b1, 1'b1, 3'd1, 6'b000000);
    idle_cycles(18);
    // 'A'
    run_cycle(1'b1, 1'b1, 3'd2, 6'b000010);
    idle_cycles(34);
    // word space
    run_cycle(1'b1, 1'b1, 3'd0, 6'b000000);
    idle_cycles(18);
    // back-to-back 'T' with valid held
    for (int i = 0; i < 40; i++) begin
      run_cycle(1'b1, 1'b1, 3'd1, 6'b000001);
    end
    idle_cycles(20);
    // len 7 clamps to six dashes
    run_cycle(1'b1, 1'b1, 3'd7, 6'b111111);
    idle_cycles(106);
    // pause mid-dash
    run_cycle(1'b1, 1'b1, 3'd1, 6'b000001);
    idle_cycles(5);
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b0, 1'b0, 3'd0, 6'd0);
    end
    idle_cycles(20);

    // reset mid-dash, between clock edges
    run_cycle(1'b1, 1'b1, 3'd1, 6'b000001);
    idle_cycles(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_key", 32'(key_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    tl.delete();
    done_pend = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycle(1'b1, 1'b1, 3'd1, 6'b000000);
    idle_cycles(18);

    // random traffic with random pauses
    for (int i = 0; i < 3000; i++) begin
      logic e;
      if (pause_left > 0) begin
        pause_left--;
        e = 1'b0;
      end else if ($urandom_range(0, 99) < 3) begin
        pause_left = $urandom_range(0, 9);
        e = 1'b0;
      end else begin
        e = 1'b1;
      end
      run_cycle(e,
                1'($urandom_range(0, 3) != 0),
                3'($urandom_range(0, 7)),
                6'($urandom));
    end
    idle_cycles(120);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
